plot_framebuffer: RTL

Pixel-plot responder and VGA scanout for the 160x120, 3-bit colour display path. It accepts single-pixel writes on the (x, y, colour, plot) interface used by our drawing blocks and stores them in an internal 19200-entry frame memory. It continuously scans that memory out as 640x480 at 60 Hz, replicating each stored pixel 4x4. After reset it clears the memory to a fixed colour and reports busy while doing so.

---
 rtl/plot_framebuffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/plot_framebuffer.sv
// Pixel-plot frame store (160x120x3) with a 640x480@60 VGA scanout, each stored pixel shown 4x4.
// After reset the store is cleared to CLEAR_COLOUR, and busy is high while that happens.
module plot_framebuffer #(
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK,
  output logic       VGA_SYNC,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam logic [14:0] MEM_LAST = 15'd19199;
  localparam logic [9:0]  H_VIS = 10'd640, H_SYNC_S = 10'd656, H_SYNC_E = 10'd751, H_MAX = 10'd799;
  localparam logic [9:0]  V_VIS = 10'd480, V_SYNC_S = 10'd490, V_SYNC_E = 10'd491, V_MAX = 10'd524;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        pix_en_q, vga_clk_q;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        vis1_q, hs1_q, vs1_q;
  logic        hs_q, vs_q, blank_q;
  logic [9:0]  r_q, g_q, b_q;
  logic [2:0]  rd_data_q;
  logic [2:0]  mem_q [0:19199];

  logic        we;
  logic [14:0] wr_addr, plot_addr, rd_addr;
  logic [2:0]  wr_data;
  logic        in_range, vis0, hs0, vs0;

  assign plot_addr = 15'(y) * 15'd160 + 15'(x);
  assign in_range  = (x < 8'd160) && (y < 7'd120);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    wr_addr    = plot_addr;
    wr_data    = colour;
    case (state_q)
      S_CLEAR: begin
        we      = 1'b1;
        wr_addr = clr_addr_q;
        wr_data = CLEAR_COLOUR;
        if (clr_addr_q == MEM_LAST) state_d = S_RUN;
        else                        clr_addr_d = clr_addr_q + 15'd1;
      end
      S_RUN:   we = plot && in_range;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      h_d = '0;
      v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
    end
  end

  assign vis0    = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs0     = !((h_q >= H_SYNC_S) && (h_q <= H_SYNC_E));
  assign vs0     = !((v_q >= V_SYNC_S) && (v_q <= V_SYNC_E));
  // Out-of-view positions would address past the store, so park the read on 0.
  assign rd_addr = vis0 ? (15'(v_q[9:2]) * 15'd160 + 15'(h_q[9:2])) : 15'd0;

  always_ff @(posedge CLOCK_50) begin
    if (we) mem_q[wr_addr] <= wr_data;
    if (pix_en_q) rd_data_q <= mem_q[rd_addr];
  end

  // Two pixel-rate stages: memory read + sync decode, then output register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      pix_en_q   <= 1'b0;
      vga_clk_q  <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      vis1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pix_en_q   <= ~pix_en_q;
      vga_clk_q  <= ~pix_en_q;
      if (pix_en_q) begin
        h_q     <= h_d;
        v_q     <= v_d;
        vis1_q  <= vis0;
        hs1_q   <= hs0;
        vs1_q   <= vs0;
        hs_q    <= hs1_q;
        vs_q    <= vs1_q;
        blank_q <= vis1_q;
        r_q     <= {10{vis1_q & rd_data_q[2]}};
        g_q     <= {10{vis1_q & rd_data_q[1]}};
        b_q     <= {10{vis1_q & rd_data_q[0]}};
      end
    end
  end

  assign busy      = (state_q == S_CLEAR);
  assign VGA_CLK   = vga_clk_q;
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign VGA_BLANK = blank_q;
  assign VGA_SYNC  = 1'b1;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;

endmodule
